// File: rtl/param_register_file_if.sv
// Bus bundle for param_register_file: two write ports, two read ports,
// dirty-clear strobe, plus the full-register and status views.
interface param_register_file_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 2
);
  logic                           write_enable0;
  logic [ADDR_WIDTH-1:0]          write_select0;
  logic [DATA_WIDTH-1:0]          write_data0;
  logic                           write_enable1;
  logic [ADDR_WIDTH-1:0]          write_select1;
  logic [DATA_WIDTH-1:0]          write_data1;
  logic [ADDR_WIDTH-1:0]          read_port0_select;
  logic [ADDR_WIDTH-1:0]          read_port1_select;
  logic                           clear_dirty;
  logic [DATA_WIDTH-1:0]          reg_output0;
  logic [DATA_WIDTH-1:0]          reg_output1;
  logic [NUM_REGS*DATA_WIDTH-1:0] reg_all;
  logic [NUM_REGS-1:0]            dirty;
  logic                           write_collision;

  modport master (
    output write_enable0, write_select0, write_data0,
    output write_enable1, write_select1, write_data1,
    output read_port0_select, read_port1_select, clear_dirty,
    input  reg_output0, reg_output1, reg_all, dirty, write_collision
  );

  modport slave (
    input  write_enable0, write_select0, write_data0,
    input  write_enable1, write_select1, write_data1,
    input  read_port0_select, read_port1_select, clear_dirty,
    output reg_output0, reg_output1, reg_all, dirty, write_collision
  );
endinterface

// File: rtl/param_register_file.sv
// Parametrised 2-write/2-read register file with port-1 write priority,
// optional write-to-read bypass, per-register dirty mask and collision flag.
module param_register_file_cell #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [DATA_WIDTH-1:0] d0,
  input  logic [DATA_WIDTH-1:0] d1,
  input  logic                  clear_dirty,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  dirty
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= RESET_VALUE;
      dirty <= 1'b0;
    end else begin
      if (we1)      q <= d1;
      else if (we0) q <= d0;
      // a write in the same cycle as a clear leaves the bit set
      if (we0 || we1)       dirty <= 1'b1;
      else if (clear_dirty) dirty <= 1'b0;
    end
  end
endmodule

module param_register_file #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    NUM_REGS    = 4,
  parameter int                    ADDR_WIDTH  = 2,
  parameter int                    BYPASS      = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input logic                 clk,
  input logic                 rst,
  param_register_file_if.slave rf
);
  localparam logic [ADDR_WIDTH:0] NREGS = (ADDR_WIDTH+1)'(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [NUM_REGS-1:0]                 dirty;
  logic                                w0_ok, w1_ok, coll;
  logic [1:0][ADDR_WIDTH-1:0]          rsel;
  logic [1:0][DATA_WIDTH-1:0]          rdata;

  // out-of-range selects are dropped before decode, collision and bypass
  assign w0_ok = rf.write_enable0 && ({1'b0, rf.write_select0} < NREGS);
  assign w1_ok = rf.write_enable1 && ({1'b0, rf.write_select1} < NREGS);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic hit0, hit1;
    assign hit0 = rf.write_enable0 && (rf.write_select0 == ADDR_WIDTH'(i));
    assign hit1 = rf.write_enable1 && (rf.write_select1 == ADDR_WIDTH'(i));
    param_register_file_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .RESET_VALUE(RESET_VALUE)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .we0        (hit0),
      .we1        (hit1),
      .d0         (rf.write_data0),
      .d1         (rf.write_data1),
      .clear_dirty(rf.clear_dirty),
      .q          (regs[i]),
      .dirty      (dirty[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) coll <= 1'b0;
    else     coll <= w0_ok && w1_ok && (rf.write_select0 == rf.write_select1);
  end

  assign rsel = {rf.read_port1_select, rf.read_port0_select};

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = '0;
      for (int i = 0; i < NUM_REGS; i++)
        if (rsel[p] == ADDR_WIDTH'(i)) rdata[p] = regs[i];
      // port 1 checked last so it wins the forward
      if (BYPASS != 0 && !rst) begin
        if (w0_ok && rf.write_select0 == rsel[p]) rdata[p] = rf.write_data0;
        if (w1_ok && rf.write_select1 == rsel[p]) rdata[p] = rf.write_data1;
      end
    end
  end

  assign rf.reg_output0     = rdata[0];
  assign rf.reg_output1     = rdata[1];
  assign rf.reg_all         = regs;
  assign rf.dirty           = dirty;
  assign rf.write_collision = coll;
endmodule
